// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   PARITY_*   : parity mode encodings (none / odd / even)
//   tx_state_e : transmitter FSM states
//   frame_bits : serial bit periods in one complete frame
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // start + data + optional parity + stop
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready word handshake into the UART transmit FIFO.
//   data  : word offered by the producer
//   valid : producer has a word on data
//   ready : transmitter can take a word this cycle
// Modports: master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and an occupancy count.
//   clock, reset_n : rising-edge clock, synchronous active-low reset (clears pointers)
//   push, wdata    : write wdata when push && !full
//   pop, rdata     : rdata shows the head word; pop && !empty advances it
//   full, empty    : occupancy flags
//   level          : words currently stored (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // one extra pointer bit tells full apart from empty
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wptr - rptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO through a valid/ready handshake.
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   tx (slave)     : data/valid in, ready out (ready = !full, low during reset)
//   pin            : serial TX line, idles high
//   frame_done     : one-cycle pulse after the last stop bit of every frame
//   busy           : frame in flight or words still queued
//   level          : FIFO occupancy
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1);
// each bit lasts CLOCKS_PER_BIT cycles. Queued frames follow with no idle gap.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLOCKS_PER_BIT = 1,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = PARITY_NONE,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  uart_tx_fifo_if.slave               tx,
  output logic                        pin,
  output logic                        frame_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int TW = $clog2(CLOCKS_PER_BIT + 1);
  localparam int IW = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));

  if (CLOCKS_PER_BIT < 1) begin : g_bad_cpb
    $fatal(1, "uart_tx_fifo: CLOCKS_PER_BIT must be >= 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_par
    $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            state;
  logic [TW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bit;
  logic                 full, empty, push, pop, wrap, last_stop;
  logic [DATA_BITS-1:0] fifo_q;

  // gating with reset_n keeps ready low during the reset cycle even if full
  assign tx.ready  = reset_n && !full;
  assign push      = tx.valid && tx.ready;
  assign wrap      = (cnt == TW'(CLOCKS_PER_BIT - 1));
  assign last_stop = (bit_idx == IW'(STOP_BITS - 1));
  assign busy      = (state != ST_IDLE) || !empty;

  // pop from idle, or at the very edge the last stop bit ends (back-to-back)
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == ST_IDLE)                            pop = 1'b1;
      else if (state == ST_STOP && wrap && last_stop) pop = 1'b1;
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (tx.data),
    .pop     (pop),
    .rdata   (fifo_q),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      par_bit    <= 1'b0;
      pin        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cnt        <= (state == ST_IDLE || wrap) ? '0 : cnt + TW'(1);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_START;
            sh      <= fifo_q;
            par_bit <= (^fifo_q) ^ (PARITY == PARITY_ODD);
            pin     <= 1'b0;
          end
        end
        ST_START: begin
          if (wrap) begin
            state   <= ST_DATA;
            pin     <= sh[0];
            sh      <= sh >> 1;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (wrap) begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                pin   <= par_bit;
              end else begin
                state <= ST_STOP;
                pin   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              pin     <= sh[0];
              sh      <= sh >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (wrap) begin
            state <= ST_STOP;
            pin   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (wrap) begin
            if (last_stop) begin
              frame_done <= 1'b1;
              bit_idx    <= '0;
              if (pop) begin
                state   <= ST_START;
                sh      <= fifo_q;
                par_bit <= (^fifo_q) ^ (PARITY == PARITY_ODD);
                pin     <= 1'b0;
              end else begin
                state <= ST_IDLE;
                pin   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          pin   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitter configurations side by side.
//   0: CPB=4, 8N1      (basic, back-to-back, backpressure, mid-frame reset)
//   1: CPB=2, 7E2      2: CPB=2, 7O2      3: CPB=1, 8N1
// Accepted words go into per-instance queues; frame monitors pop them and
// check every serial cycle plus the frame_done pulse.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      pin, fd, busy;
  logic [3:0][2:0] lvl;
  int checks = 0;
  int errors = 0;
  logic [8:0] qa[$], qb[$], qc[$], qd[$];

  uart_tx_fifo_if #(.DATA_BITS(8)) ia ();
  uart_tx_fifo_if #(.DATA_BITS(7)) ib ();
  uart_tx_fifo_if #(.DATA_BITS(7)) ic ();
  uart_tx_fifo_if #(.DATA_BITS(8)) id ();

  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clock(clk), .reset_n(rst_n), .tx(ia), .pin(pin[0]), .frame_done(fd[0]), .busy(busy[0]), .level(lvl[0]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(2), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clock(clk), .reset_n(rst_n), .tx(ib), .pin(pin[1]), .frame_done(fd[1]), .busy(busy[1]), .level(lvl[1]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(2), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clock(clk), .reset_n(rst_n), .tx(ic), .pin(pin[2]), .frame_done(fd[2]), .busy(busy[2]), .level(lvl[2]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
    .clock(clk), .reset_n(rst_n), .tx(id), .pin(pin[3]), .frame_done(fd[3]), .busy(busy[3]), .level(lvl[3]));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] pop_q(input int idx);
    logic [9:0] r = '0;
    case (idx)
      0: if (qa.size() > 0) r = {1'b1, qa.pop_front()};
      1: if (qb.size() > 0) r = {1'b1, qb.pop_front()};
      2: if (qc.size() > 0) r = {1'b1, qc.pop_front()};
      default: if (qd.size() > 0) r = {1'b1, qd.pop_front()};
    endcase
    return r;
  endfunction

  // Checks one whole frame cycle by cycle; called at a negedge that is either
  // before the frame (wait_start) or exactly its first start-bit cycle.
  // Returns at the sample after the last stop cycle, where frame_done must be 1.
  task automatic frame_check(input int idx, input int cpb, input int db, input int par,
                             input int stp, input bit wait_start, input string nm);
    logic       eb [16];
    int         nb, n;
    logic       p;
    logic [9:0] r;
    if (wait_start) begin
      n = 0;
      while (pin[idx] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      checks++;
      if (n >= 400) begin
        errors++;
        $display("FAIL %s start: pin=%b, required 0 within 400 cycles", nm, pin[idx]);
        return;
      end
    end
    r = pop_q(idx);
    checks++;
    if (!r[9]) begin
      errors++;
      $display("FAIL %s scoreboard: frame started with queue empty, required a queued word", nm);
      return;
    end
    nb = 0; p = 1'b0;
    eb[nb] = 1'b0; nb++;
    for (int i = 0; i < db; i++) begin eb[nb] = r[i]; p = p ^ r[i]; nb++; end
    if (par != 0) begin eb[nb] = (par == 1) ? ~p : p; nb++; end
    for (int i = 0; i < stp; i++) begin eb[nb] = 1'b1; nb++; end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        checks++;
        if (pin[idx] !== eb[b] || (!(b == 0 && c == 0) && fd[idx] !== 1'b0)) begin
          errors++;
          $display("FAIL %s word %h bit %0d cyc %0d: pin=%b fd=%b, required pin=%b fd=0",
                   nm, r[8:0], b, c, pin[idx], fd[idx], eb[b]);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (fd[idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_done: got %b, required 1 after %0d cycles", nm, fd[idx], nb * cpb);
    end
  endtask

  // Offers w on instance 0 until accepted; returns at the negedge after the accepting edge.
  task automatic drive_a(input logic [7:0] w, output int waited, output int lv);
    int n = 0;
    ia.data  = w;
    ia.valid = 1'b1;
    while (ia.ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    waited = n;
    lv     = int'(lvl[0]);
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drive %h: ready=%b, required 1 within 300 cycles", w, ia.ready);
    end else begin
      qa.push_back({1'b0, w});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ia.valid = 1'b0; ib.valid = 1'b0; ic.valid = 1'b0; id.valid = 1'b0;
    ia.data = '0; ib.data = '0; ic.data = '0; id.data = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pin[i] !== 1'b1 || fd[i] !== 1'b0 || busy[i] !== 1'b0 || lvl[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset inst %0d: pin=%b fd=%b busy=%b level=%0d, required 1 0 0 0",
                 i, pin[i], fd[i], busy[i], lvl[i]);
      end
    end
    checks++;
    if (ia.ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b, required 0", ia.ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ia.ready !== 1'b1 || id.ready !== 1'b1) begin
      errors++;
      $display("FAIL post-reset ready: got %b/%b, required 1/1", ia.ready, id.ready);
    end
  endtask

  task automatic test_basic();
    int wt, lv;
    drive_a(8'hA5, wt, lv);
    ia.valid = 1'b0;
    checks++;
    if (pin[0] !== 1'b1 || busy[0] !== 1'b1 || lvl[0] !== 3'd1) begin
      errors++;
      $display("FAIL basic accept: pin=%b busy=%b level=%0d, required 1 1 1", pin[0], busy[0], lvl[0]);
    end
    @(negedge clk);
    checks++;
    if (pin[0] !== 1'b0) begin errors++; $display("FAIL basic latency: pin=%b, required 0", pin[0]); end
    frame_check(0, 4, 8, 0, 1, 1'b1, "basic");
    checks++;
    if (busy[0] !== 1'b0 || pin[0] !== 1'b1 || lvl[0] !== 3'd0) begin
      errors++;
      $display("FAIL basic end: busy=%b pin=%b level=%0d, required 0 1 0", busy[0], pin[0], lvl[0]);
    end
    @(negedge clk);
    checks++;
    if (fd[0] !== 1'b0) begin errors++; $display("FAIL basic fd width: fd=%b, required 0", fd[0]); end
  endtask

  task automatic test_back_to_back();
    int wt, lv;
    fork
      begin
        drive_a(8'h01, wt, lv);
        drive_a(8'h02, wt, lv);
        drive_a(8'h03, wt, lv);
        ia.valid = 1'b0;
      end
      begin
        frame_check(0, 4, 8, 0, 1, 1'b1, "b2b0");
        frame_check(0, 4, 8, 0, 1, 1'b0, "b2b1");
        frame_check(0, 4, 8, 0, 1, 1'b0, "b2b2");
      end
    join
    checks++;
    if (busy[0] !== 1'b0 || pin[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b end: busy=%b pin=%b, required 0 1", busy[0], pin[0]);
    end
    @(negedge clk);
    checks++;
    if (fd[0] !== 1'b0) begin errors++; $display("FAIL b2b fd width: fd=%b, required 0", fd[0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ws [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int wt, lv;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          drive_a(ws[i], wt, lv);
          if (i < 5) begin
            checks++;
            if (wt != 0) begin errors++; $display("FAIL bp accept %0d: waited %0d, required 0", i, wt); end
          end
          if (i == 4) begin
            checks++;
            if (ia.ready !== 1'b0 || lvl[0] !== 3'd4) begin
              errors++;
              $display("FAIL bp full: ready=%b level=%0d, required 0 4", ia.ready, lvl[0]);
            end
          end
          if (i == 5) begin
            checks++;
            if (wt == 0 || lv != 3) begin
              errors++;
              $display("FAIL bp late accept: waited %0d level %0d, required >0 and 3", wt, lv);
            end
          end
        end
        ia.valid = 1'b0;
      end
      begin
        frame_check(0, 4, 8, 0, 1, 1'b1, "bp0");
        for (int i = 1; i < 6; i++) frame_check(0, 4, 8, 0, 1, 1'b0, "bpN");
      end
    join
    checks++;
    if (busy[0] !== 1'b0 || lvl[0] !== 3'd0 || qa.size() != 0) begin
      errors++;
      $display("FAIL bp end: busy=%b level=%0d left=%0d, required 0 0 0", busy[0], lvl[0], qa.size());
    end
  endtask

  task automatic test_parity();
    ib.data = 7'h13; ib.valid = 1'b1;
    checks++;
    if (ib.ready !== 1'b1) begin errors++; $display("FAIL even ready: got %b, required 1", ib.ready); end
    else qb.push_back(9'h013);
    @(negedge clk);
    ib.valid = 1'b0;
    frame_check(1, 2, 7, 2, 2, 1'b1, "even");
    ic.data = 7'h13; ic.valid = 1'b1;
    checks++;
    if (ic.ready !== 1'b1) begin errors++; $display("FAIL odd ready: got %b, required 1", ic.ready); end
    else qc.push_back(9'h013);
    @(negedge clk);
    ic.valid = 1'b0;
    frame_check(2, 2, 7, 1, 2, 1'b1, "odd");
    checks++;
    if (busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL parity end busy: got %b/%b, required 0/0", busy[1], busy[2]);
    end
  endtask

  task automatic test_cpb1();
    id.data = 8'hFF; id.valid = 1'b1;
    checks++;
    if (id.ready !== 1'b1) begin errors++; $display("FAIL cpb1 ready: got %b, required 1", id.ready); end
    else qd.push_back(9'h0FF);
    @(negedge clk);
    id.valid = 1'b0;
    frame_check(3, 1, 8, 0, 1, 1'b1, "cpb1");
    checks++;
    if (busy[3] !== 1'b0 || pin[3] !== 1'b1) begin
      errors++;
      $display("FAIL cpb1 end: busy=%b pin=%b, required 0 1", busy[3], pin[3]);
    end
  endtask

  task automatic test_reset_mid();
    int wt, lv, n;
    bit bad;
    fork
      begin
        drive_a(8'hC3, wt, lv);
        drive_a(8'h3C, wt, lv);
        drive_a(8'h5A, wt, lv);
        ia.valid = 1'b0;
      end
      begin
        n = 0;
        while (pin[0] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        repeat (17) @(negedge clk);   // inside data bit 3
        checks++;
        if (lvl[0] !== 3'd2) begin errors++; $display("FAIL rst-mid queued: level=%0d, required 2", lvl[0]); end
        rst_n = 1'b0;
      end
    join
    @(negedge clk);
    checks++;
    if (pin[0] !== 1'b1 || lvl[0] !== 3'd0 || fd[0] !== 1'b0 || busy[0] !== 1'b0 || ia.ready !== 1'b0) begin
      errors++;
      $display("FAIL rst-mid edge: pin=%b level=%0d fd=%b busy=%b ready=%b, required 1 0 0 0 0",
               pin[0], lvl[0], fd[0], busy[0], ia.ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ia.ready !== 1'b1) begin errors++; $display("FAIL rst-mid ready: got %b, required 1", ia.ready); end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pin[0] !== 1'b1 || fd[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst-mid quiet: activity seen after reset, required idle line"); end
    qa.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_parity();
    test_cpb1();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO and a valid/ready input handshake. It sits between on-chip producers (command encoders, telemetry packers) and the serial TX pin. It generalises the single-byte sender with:
- configurable data width, parity and stop bits;
- back-to-back frames with no idle gap;
- buffering of up to FIFO_DEPTH words.

## Interface
- CLOCKS_PER_BIT, 1, clock cycles per serial bit; ≥1, and 1 must work.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4, words buffered; power of two, ≥2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset: one clock, synchronous, active-low.
- data  in  DATA_BITS  word to transmit.
- valid  in  1  producer offers `data`.
- ready  out  1  FIFO can accept a word; equals !full.
- pin  out  1  serial TX line; idle high.
- frame_done  out  1  one-cycle pulse when the last stop bit of a frame completes.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: a word is written at any edge where valid && ready. valid while !ready is ignored; no word is lost or overwritten.
- Frame format, each bit driven for exactly CLOCKS_PER_BIT cycles, in this order:
  - start bit (0);
  - DATA_BITS data bits, LSB first;
  - parity bit, if PARITY≠0;
  - STOP_BITS stop bits (1).
- Parity:
  - odd: the data bits plus the parity bit contain an odd number of 1s;
  - even: the data bits plus the parity bit contain an even number of 1s.
  - Computed from the word latched at pop time.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty: pop, latch the word, pin←0.
  - START → DATA after CLOCKS_PER_BIT cycles.
  - DATA → PARITY or STOP after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START directly if the FIFO is non-empty (pop at the same edge); otherwise → IDLE with pin=1.
- Bit timer: counter of width $clog2(CLOCKS_PER_BIT+1). It wraps at CLOCKS_PER_BIT−1; the bit index advances on the wrap.
- The latched word is held in a shift register. FIFO contents may change during a frame without affecting the frame in flight.

## Timing
- Reset values: pin=1, ready=0 during reset and 1 the cycle after, frame_done=0, busy=0, level=0. FSM goes to IDLE; FIFO pointers are cleared.
- Latency: word accepted at edge k into an empty FIFO while IDLE → pin low after edge k+1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLOCKS_PER_BIT cycles, exact.
- Consecutive frames: the next start bit begins on the cycle right after the final stop-bit cycle; zero idle cycles.
- frame_done: asserted for exactly one cycle, coincident with the edge that ends the last stop bit. It is raised for every frame, including back-to-back frames.
- Simultaneous push and pop on the same edge: both take effect and level is unchanged.
- Full FIFO: ready=0. A pop makes ready=1 from the following cycle.
- Reset mid-frame: at the reset edge pin returns to 1, the frame is abandoned and the FIFO is flushed. No frame_done is raised for the abandoned frame.

## Structure
- Shared package `uart_pkg`:
  - parity mode constants PARITY_NONE/ODD/EVEN;
  - FSM state typedef;
  - function `frame_bits(DATA_BITS, PARITY, STOP_BITS)`.
  - The future uart_rx uses the same package.
- One sub-module `sync_fifo` (parameters WIDTH and DEPTH; ports push/pop/full/empty/level), reused elsewhere.
- The top level holds the FSM, bit timer, shift register and parity.
- Parameter legality is checked at elaboration; an illegal value is a fatal error.

## Test plan
- Basic frame: defaults, CLOCKS_PER_BIT=4, push 0xA5 → pin is low for 4 cycles, then data bits 1,0,1,0,0,1,0,1 (LSB first), then high for 4 cycles. frame_done fires once, 40 cycles after pin falls.
- Parity and stop bits, DATA_BITS=7:
  - PARITY=2 (even), STOP_BITS=2, push 0x13 → parity bit 1, two stop bits, frame of 11 bit periods.
  - PARITY=1 (odd) → parity bit 0.
- Back-to-back: push 0x01, 0x02, 0x03 in consecutive cycles → three contiguous frames with no idle high between them, three frame_done pulses, busy drops one cycle after the last stop bit.
- Backpressure: FIFO_DEPTH=4, hold valid with 6 distinct words → ready falls after 5 accepts (4 in FIFO + 1 popped). The remaining word is accepted when the first frame pops the next one. All 6 are transmitted in order, with none dropped or duplicated.
- CLOCKS_PER_BIT=1: push 0xFF → 10-cycle frame, each bit exactly 1 cycle.
- Reset mid-frame: assert reset_n=0 during data bit 3 with 2 words queued → pin=1 and level=0 after that edge, no frame_done, no further frames.
